// File: rtl/mmu_skew_a_pkg.sv
// Shared definitions for the MMU operand path: default array geometry and
// the skewer's FSM state encoding.
package mmu_skew_a_pkg;

    localparam int VAR_SIZE_DEF = 8;
    localparam int MMU_SIZE_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/mmu_skew_a_if.sv
// Column-stream bus between the A buffer, the skewer and the MMU rows.
// The master side drives the stream controls, the slave side returns skewed lanes.
interface mmu_skew_a_if #(
    parameter int VAR_SIZE = mmu_skew_a_pkg::VAR_SIZE_DEF,
    parameter int MMU_SIZE = mmu_skew_a_pkg::MMU_SIZE_DEF
);
    logic                         stop;
    logic                         start;
    logic [7:0]                   dim_y_in;
    logic [VAR_SIZE*MMU_SIZE-1:0] B1_in;
    logic [VAR_SIZE*MMU_SIZE-1:0] A_out;
    logic [MMU_SIZE-1:0]          lane_valid;
    logic                         busy;
    logic                         done;

    modport master (
        output stop, start, dim_y_in, B1_in,
        input  A_out, lane_valid, busy, done
    );

    modport slave (
        input  stop, start, dim_y_in, B1_in,
        output A_out, lane_valid, busy, done
    );
endinterface

// File: rtl/mmu_skew_a_skew_lane.sv
// Enable-gated delay line carrying one signed element plus its valid tag;
// DEPTH register stages, output forced to zero when the tag is low.
module skew_lane #(
    parameter int VAR_SIZE = 8,
    parameter int DEPTH    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [VAR_SIZE-1:0] din,
    input  logic                vin,
    output logic [VAR_SIZE-1:0] dout,
    output logic                vout
);
    logic [VAR_SIZE-1:0] data_q [DEPTH];
    logic                vld_q  [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                vld_q[k]  <= 1'b0;
            end
        end else if (en) begin
            data_q[0] <= din;
            vld_q[0]  <= vin;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k] <= data_q[k-1];
                vld_q[k]  <= vld_q[k-1];
            end
        end
    end

    assign vout = vld_q[DEPTH-1];
    assign dout = vld_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/mmu_skew_a.sv
// Diagonal skewer: streams dim_y columns into per-lane delay lines (lane i delayed
// by i extra cycles), then drains for MMU_SIZE cycles and pulses done.
module mmu_skew_a
    import mmu_skew_a_pkg::*;
#(
    parameter int VAR_SIZE = VAR_SIZE_DEF,
    parameter int MMU_SIZE = MMU_SIZE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    mmu_skew_a_if.slave bus
);
    localparam int DW = $clog2(MMU_SIZE) + 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MMU_SIZE - 1);

    state_t        state, state_nxt;
    logic [7:0]    dim_y, dim_y_nxt;
    logic [7:0]    col_cnt, col_cnt_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          zero_done, zero_done_nxt;

    logic                         shift_en;
    logic                         feed_valid;
    logic [VAR_SIZE*MMU_SIZE-1:0] feed_data;
    logic [VAR_SIZE-1:0]          lane_data [MMU_SIZE];
    logic                         lane_vld  [MMU_SIZE];

    assign shift_en   = !bus.stop;
    assign feed_valid = (state == ST_STREAM);
    assign feed_data  = feed_valid ? bus.B1_in : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dim_y     <= '0;
            col_cnt   <= '0;
            drain_cnt <= '0;
            zero_done <= 1'b0;
        end else if (shift_en) begin
            state     <= state_nxt;
            dim_y     <= dim_y_nxt;
            col_cnt   <= col_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            zero_done <= zero_done_nxt;
        end
    end

    // Column count compares against dim_y-1 so a 255-column stream never wraps.
    always_comb begin
        state_nxt     = state;
        dim_y_nxt     = dim_y;
        col_cnt_nxt   = col_cnt;
        drain_cnt_nxt = drain_cnt;
        zero_done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.dim_y_in == 8'd0) begin
                        zero_done_nxt = 1'b1;
                    end else begin
                        state_nxt   = ST_STREAM;
                        dim_y_nxt   = bus.dim_y_in;
                        col_cnt_nxt = '0;
                    end
                end
            end
            ST_STREAM: begin
                if (col_cnt == dim_y - 8'd1) begin
                    state_nxt     = ST_DRAIN;
                    col_cnt_nxt   = '0;
                    drain_cnt_nxt = '0;
                end else begin
                    col_cnt_nxt = col_cnt + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt     = ST_IDLE;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = zero_done || ((state == ST_DRAIN) && (drain_cnt == DRAIN_LAST));

    for (genvar i = 0; i < MMU_SIZE; i++) begin : g_lane
        skew_lane #(
            .VAR_SIZE (VAR_SIZE),
            .DEPTH    (i + 1)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (shift_en),
            .din   (feed_data[i*VAR_SIZE +: VAR_SIZE]),
            .vin   (feed_valid),
            .dout  (lane_data[i]),
            .vout  (lane_vld[i])
        );
    end

    always_comb begin
        bus.A_out      = '0;
        bus.lane_valid = '0;
        for (int i = 0; i < MMU_SIZE; i++) begin
            bus.A_out[i*VAR_SIZE +: VAR_SIZE] = lane_data[i];
            bus.lane_valid[i]                 = lane_vld[i];
        end
    end

endmodule

// File: tb/tb_mmu_skew_a.sv
// Scoreboard bench for mmu_skew_a: stimulus queues expected (cycle, lane, value)
// and done cycles; a negedge monitor pops and compares whatever the DUT presents.
module tb_mmu_skew_a;
    localparam int VS = 8;
    localparam int MS = 10;

    typedef struct {
        int         cyc;
        int         lane;
        logic [7:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   b_lo = 1;
    int   b_hi = 0;

    exp_t sb[$];
    int   done_q[$];

    logic [VS*MS-1:0] prev_a;
    logic [MS-1:0]    prev_v;
    logic             prev_d;
    logic             prev_b;
    logic             prev_stop = 1'b0;

    mmu_skew_a_if #(.VAR_SIZE(VS), .MMU_SIZE(MS)) bus ();

    mmu_skew_a #(.VAR_SIZE(VS), .MMU_SIZE(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [7:0] colVal(input int c, input int i, input bit pat);
        if (pat) return (((c + i) % 2) == 0) ? 8'h80 : 8'h7F;
        return 8'(16 * c + i);
    endfunction

    function automatic logic [VS*MS-1:0] colBits(input int c, input bit pat);
        logic [VS*MS-1:0] v;
        for (int i = 0; i < MS; i++) v[i*VS +: VS] = colVal(c, i, pat);
        return v;
    endfunction

    function automatic logic [VS*MS-1:0] junk();
        logic [VS*MS-1:0] v;
        for (int i = 0; i < MS; i++) v[i*VS +: VS] = 8'($urandom);
        return v;
    endfunction

    task automatic checkOutput(input string name);
        checks++;
        if (bus.A_out !== '0 || bus.lane_valid !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: A_out=%h lane_valid=%b busy=%b done=%b, required all zero",
                     name, bus.A_out, bus.lane_valid, bus.busy, bus.done);
        end
    endtask

    // Monitor: scoreboard compare on live cycles, hold compare on cycles after a stall.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            checkOutput("reset_outputs");
            sb.delete();
            done_q.delete();
            prev_stop = 1'b0;
        end else begin
            if (prev_stop) begin
                checks++;
                if (bus.A_out !== prev_a || bus.lane_valid !== prev_v ||
                    bus.done !== prev_d || bus.busy !== prev_b) begin
                    errors++;
                    $display("[TB] FAIL freeze cyc=%0d: A_out=%h lv=%b done=%b busy=%b, required held %h %b %b %b",
                             cyc, bus.A_out, bus.lane_valid, bus.done, bus.busy, prev_a, prev_v, prev_d, prev_b);
                end
            end else begin
                logic bad_zero;
                bad_zero = 1'b0;
                for (int i = 0; i < MS; i++) begin
                    logic [7:0] d;
                    d = bus.A_out[i*VS +: VS];
                    if (bus.lane_valid[i]) begin
                        bit   found;
                        exp_t e;
                        found = 1'b0;
                        for (int j = 0; j < sb.size(); j++) begin
                            if (!found && sb[j].lane == i) begin
                                e = sb[j];
                                sb.delete(j);
                                found = 1'b1;
                            end
                        end
                        checks++;
                        if (!found) begin
                            errors++;
                            $display("[TB] FAIL lane%0d cyc=%0d: unexpected valid value %h, required no valid", i, cyc, d);
                        end else if (e.cyc != cyc || e.val !== d) begin
                            errors++;
                            $display("[TB] FAIL lane%0d cyc=%0d: got %h, required %h at cycle %0d", i, cyc, d, e.val, e.cyc);
                        end
                    end else if (d !== 8'h00) begin
                        bad_zero = 1'b1;
                    end
                end
                checks++;
                if (bad_zero) begin
                    errors++;
                    $display("[TB] FAIL invalid_zero cyc=%0d: A_out=%h lv=%b, required 0 on invalid lanes", cyc, bus.A_out, bus.lane_valid);
                end
                if (bus.done === 1'b1) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL done cyc=%0d: done=1, required 0", cyc);
                    end else begin
                        int dc;
                        dc = done_q.pop_front();
                        if (dc != cyc) begin
                            errors++;
                            $display("[TB] FAIL done cyc=%0d: done=1, required at cycle %0d", cyc, dc);
                        end
                    end
                end
                checks++;
                if (bus.busy !== ((cyc >= b_lo) && (cyc <= b_hi))) begin
                    errors++;
                    $display("[TB] FAIL busy cyc=%0d: got %b, required %b", cyc, bus.busy, (cyc >= b_lo) && (cyc <= b_hi));
                end
            end
            for (int j = sb.size() - 1; j >= 0; j--) begin
                if (sb[j].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL lane%0d missing: value %h never seen, required at cycle %0d", sb[j].lane, sb[j].val, sb[j].cyc);
                    sb.delete(j);
                end
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL done missing: got none, required at cycle %0d", done_q[0]);
                void'(done_q.pop_front());
            end
            prev_a    = bus.A_out;
            prev_v    = bus.lane_valid;
            prev_d    = bus.done;
            prev_b    = bus.busy;
            prev_stop = bus.stop;
        end
    end

    // One stream: expectations queued up front, then inputs driven cycle by cycle.
    task automatic applyStimulus(input int dim, input int stall_at, input int stall_len,
                                 input bit pat, input int restart_at, input int reset_at);
        int   t0, n, cidx, total;
        exp_t e;
        t0 = cyc;
        for (int c = 0; c < dim; c++) begin
            for (int i = 0; i < MS; i++) begin
                n = t0 + 2 + c + i;
                if (stall_len > 0 && n > t0 + stall_at) n = n + stall_len;
                e.cyc  = n;
                e.lane = i;
                e.val  = colVal(c, i, pat);
                sb.push_back(e);
            end
        end
        if (dim == 0) begin
            done_q.push_back(t0 + 1);
            b_lo = 1;
            b_hi = 0;
        end else begin
            n = t0 + dim + MS;
            if (stall_len > 0 && n > t0 + stall_at) n = n + stall_len;
            done_q.push_back(n);
            b_lo = t0 + 1;
            b_hi = n;
        end
        total = dim + MS + stall_len + 3;
        cidx  = 0;
        for (int k = 0; k < total; k++) begin
            bus.start    = (k == 0) || (k == restart_at);
            bus.dim_y_in = ((k == 0) || (k == restart_at)) ? 8'(dim) : 8'd7;
            bus.stop     = (stall_len > 0) && (k >= stall_at) && (k < stall_at + stall_len);
            if (k >= 1 && cidx < dim) bus.B1_in = colBits(cidx, pat);
            else                      bus.B1_in = junk();
            if (k == reset_at) begin
                bus.B1_in = junk();
                #2;
                rst_n = 1'b0;
                b_lo  = 1;
                b_hi  = 0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                break;
            end
            if (k >= 1 && !bus.stop && cidx < dim) cidx++;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.dim_y_in = 8'd0;
        bus.B1_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic stream dim_y=3");
        applyStimulus(3, 0, 0, 1'b0, -1, -1);
        $display("[TB] stall in cycles 3..4");
        applyStimulus(3, 3, 2, 1'b0, -1, -1);
        $display("[TB] signed -128/127 lanes");
        applyStimulus(2, 0, 0, 1'b1, -1, -1);
        $display("[TB] start while busy at cycle 5");
        applyStimulus(3, 0, 0, 1'b0, 5, -1);
        $display("[TB] start with dim_y=0");
        applyStimulus(0, 0, 0, 1'b0, -1, -1);
        $display("[TB] reset during stream with garbage input");
        applyStimulus(3, 0, 0, 1'b0, -1, 2);
        $display("[TB] reset mid-drain at cycle 8");
        applyStimulus(3, 0, 0, 1'b0, -1, 8);
        $display("[TB] dim_y=1 after reset");
        applyStimulus(1, 0, 0, 1'b0, -1, -1);
        $display("[TB] dim_y=255 long stream");
        applyStimulus(255, 0, 0, 1'b0, -1, -1);
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
